// File: rtl/if_id_fifo.sv
// Instruction queue between fetch and decode: in-order valid/ready FIFO
// carrying PC, instruction, IF trap bits and the branch-prediction sidecar.
`ifndef TRAP_LEN
`define TRAP_LEN 4
`endif
`ifndef HISLEN
`define HISLEN 8
`endif

module if_id_fifo #(
   parameter int DEPTH  = 4,
   parameter int TRAP_W = `TRAP_LEN,
   parameter int HIS_W  = `HISLEN
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic                       in_valid_i,
   output logic                       in_ready_o,
   input  logic [31:0]                in_pc_i,
   input  logic [31:0]                in_inst_i,
   input  logic [TRAP_W-1:0]          in_trap_i,
   input  logic                       in_pdt_res_i,
   input  logic [31:0]                in_pdt_tag_i,
   input  logic                       in_which_pdt_i,
   input  logic [HIS_W-1:0]           in_history_i,
   output logic                       out_valid_o,
   input  logic                       out_ready_i,
   output logic [31:0]                out_pc_o,
   output logic [31:0]                out_inst_o,
   output logic [TRAP_W-1:0]          out_trap_o,
   output logic                       out_pdt_res_o,
   output logic [31:0]                out_pdt_tag_o,
   output logic                       out_which_pdt_o,
   output logic [HIS_W-1:0]           out_history_o,
   output logic                       fetch_stall_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [31:0]       mem_pc   [DEPTH];
   logic [31:0]       mem_inst [DEPTH];
   logic [TRAP_W-1:0] mem_trap [DEPTH];
   logic              mem_res  [DEPTH];
   logic [31:0]       mem_tag  [DEPTH];
   logic              mem_which[DEPTH];
   logic [HIS_W-1:0]  mem_his  [DEPTH];

   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          full_s;
   logic          empty_s;
   logic          enq_s;
   logic          deq_s;

   assign full_s        = (count_r == (AW+1)'(DEPTH));
   assign empty_s       = (count_r == {(AW+1){1'b0}});
   assign in_ready_o    = ~full_s;
   assign fetch_stall_o = full_s;
   assign out_valid_o   = ~empty_s;
   assign count_o       = count_r;
   assign enq_s         = in_valid_i & ~full_s & ~flush_i;
   assign deq_s         = ~empty_s & out_ready_i & ~flush_i;

   // Pointer and occupancy state; flush outranks enqueue and dequeue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else if (flush_i) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {(AW+1){1'b0}};
      end else begin
         if (enq_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (deq_s) rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({enq_s, deq_s})
            2'b10:   count_r <= count_r + (AW+1)'(1);
            2'b01:   count_r <= count_r - (AW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Packet storage; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (enq_s) begin
         mem_pc[wr_ptr_r]    <= in_pc_i;
         mem_inst[wr_ptr_r]  <= in_inst_i;
         mem_trap[wr_ptr_r]  <= in_trap_i;
         mem_res[wr_ptr_r]   <= in_pdt_res_i;
         mem_tag[wr_ptr_r]   <= in_pdt_tag_i;
         mem_which[wr_ptr_r] <= in_which_pdt_i;
         mem_his[wr_ptr_r]   <= in_history_i;
      end
   end

   // Head entry to ID, replaced by a NOP bubble while the queue is empty.
   always_comb begin
      out_pc_o        = 32'h0000_0000;
      out_inst_o      = 32'h0000_0013;
      out_trap_o      = {TRAP_W{1'b0}};
      out_pdt_res_o   = 1'b0;
      out_pdt_tag_o   = 32'h0000_0000;
      out_which_pdt_o = 1'b0;
      out_history_o   = {HIS_W{1'b0}};
      if (!empty_s) begin
         out_pc_o        = mem_pc[rd_ptr_r];
         out_inst_o      = mem_inst[rd_ptr_r];
         out_trap_o      = mem_trap[rd_ptr_r];
         out_pdt_res_o   = mem_res[rd_ptr_r];
         out_pdt_tag_o   = mem_tag[rd_ptr_r];
         out_which_pdt_o = mem_which[rd_ptr_r];
         out_history_o   = mem_his[rd_ptr_r];
      end else begin
         out_pc_o        = 32'h0000_0000;
      end
   end

endmodule

// File: tb/tb_if_id_fifo.sv
// Directed bench for if_id_fifo: a queue scoreboard receives each accepted
// packet and is popped and compared as ID consumes the head.
module tb_if_id_fifo;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [3:0]  trap;
      logic        res;
      logic [31:0] tag;
      logic        which;
      logic [7:0]  his;
   } pkt_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] in_pc_i = 32'h0;
   logic [31:0] in_inst_i = 32'h0;
   logic [3:0]  in_trap_i = 4'h0;
   logic        in_pdt_res_i = 1'b0;
   logic [31:0] in_pdt_tag_i = 32'h0;
   logic        in_which_pdt_i = 1'b0;
   logic [7:0]  in_history_i = 8'h0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] out_pc_o;
   logic [31:0] out_inst_o;
   logic [3:0]  out_trap_o;
   logic        out_pdt_res_o;
   logic [31:0] out_pdt_tag_o;
   logic        out_which_pdt_o;
   logic [7:0]  out_history_o;
   logic        fetch_stall_o;
   logic [2:0]  count_o;

   int   checks = 0;
   int   errors = 0;
   pkt_t sb[$];
   logic acc;

   if_id_fifo #(.DEPTH(4), .TRAP_W(4), .HIS_W(8)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .in_pc_i(in_pc_i), .in_inst_i(in_inst_i), .in_trap_i(in_trap_i),
      .in_pdt_res_i(in_pdt_res_i), .in_pdt_tag_i(in_pdt_tag_i),
      .in_which_pdt_i(in_which_pdt_i), .in_history_i(in_history_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .out_pc_o(out_pc_o), .out_inst_o(out_inst_o), .out_trap_o(out_trap_o),
      .out_pdt_res_o(out_pdt_res_o), .out_pdt_tag_o(out_pdt_tag_o),
      .out_which_pdt_o(out_which_pdt_o), .out_history_o(out_history_o),
      .fetch_stall_o(fetch_stall_o), .count_o(count_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic pkt_t mk(input logic [31:0] pc, input logic [31:0] inst);
      pkt_t p;
      p.pc = pc; p.inst = inst; p.trap = 4'h0; p.res = pc[2];
      p.tag = pc ^ 32'h5A5A_0000; p.which = pc[3]; p.his = pc[11:4];
      return p;
   endfunction

   task automatic drive(input logic v, input pkt_t p, input logic rdy, input logic fl);
      in_valid_i = v; out_ready_i = rdy; flush_i = fl;
      in_pc_i = p.pc; in_inst_i = p.inst; in_trap_i = p.trap;
      in_pdt_res_i = p.res; in_pdt_tag_i = p.tag;
      in_which_pdt_i = p.which; in_history_i = p.his;
   endtask

   // One cycle: check outputs against the scoreboard mid-cycle, then update it.
   task automatic tick(output logic accepted);
      pkt_t h;
      int   n;
      @(negedge clk);
      n = sb.size();
      check("count", 32'(count_o), 32'(n));
      check("in_ready", 32'(in_ready_o), 32'(n < 4));
      check("fetch_stall", 32'(fetch_stall_o), 32'(n == 4));
      check("out_valid", 32'(out_valid_o), 32'(n > 0));
      if (n > 0) begin
         h = sb[0];
         check("head_pc", out_pc_o, h.pc);
         check("head_inst", out_inst_o, h.inst);
         check("head_trap", 32'(out_trap_o), 32'(h.trap));
         check("head_res", 32'(out_pdt_res_o), 32'(h.res));
         check("head_tag", out_pdt_tag_o, h.tag);
         check("head_which", 32'(out_which_pdt_o), 32'(h.which));
         check("head_his", 32'(out_history_o), 32'(h.his));
      end else begin
         check("bubble_pc", out_pc_o, 32'h0000_0000);
         check("bubble_inst", out_inst_o, 32'h0000_0013);
         check("bubble_tag", out_pdt_tag_o, 32'h0000_0000);
         check("bubble_his", 32'(out_history_o), 32'h0);
      end
      accepted = 1'b0;
      if (flush_i) begin
         sb.delete();
      end else begin
         accepted = in_valid_i && (n < 4);
         if (n > 0 && out_ready_i) void'(sb.pop_front());
         if (accepted) sb.push_back({in_pc_i, in_inst_i, in_trap_i, in_pdt_res_i,
                                     in_pdt_tag_i, in_which_pdt_i, in_history_i});
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      pkt_t p;
      int   k;
      p = mk(32'h0, 32'h0);
      drive(1'b0, p, 1'b0, 1'b0);
      #12 rst = 1'b0;
      @(posedge clk); #1;

      // reset state, then single packet with ID ready
      tick(acc);
      drive(1'b1, mk(32'h8000_0000, 32'h0010_0093), 1'b1, 1'b0);
      tick(acc);
      drive(1'b0, p, 1'b1, 1'b0);
      tick(acc);
      tick(acc);

      // ID stalled: five packets offered, four fit
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, mk(32'(i * 4), 32'h0000_1013 + 32'(i)), 1'b0, 1'b0);
         tick(acc);
      end
      drive(1'b0, p, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick(acc);

      // full with simultaneous dequeue and offered packet
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, mk(32'h200 + 32'(i * 4), 32'h0000_2013), 1'b0, 1'b0);
         tick(acc);
      end
      drive(1'b1, mk(32'h300, 32'h0000_3013), 1'b1, 1'b0);
      tick(acc);
      drive(1'b1, mk(32'h300, 32'h0000_3013), 1'b0, 1'b0);
      tick(acc);
      drive(1'b0, p, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) tick(acc);

      // flush with three queued and a same-cycle input
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, mk(32'h400 + 32'(i * 4), 32'h0000_4013), 1'b0, 1'b0);
         tick(acc);
      end
      drive(1'b1, mk(32'h4FC, 32'hDEAD_0013), 1'b1, 1'b1);
      tick(acc);
      drive(1'b0, p, 1'b1, 1'b0);
      tick(acc);
      tick(acc);

      // stream ten packets with random ID stalls, across pointer wrap
      k = 0;
      for (int c = 0; c < 200 && k < 10; c++) begin
         drive(1'b1, mk(32'h1000 + 32'(k * 4), 32'h0000_5013 + 32'(k)), 1'($urandom_range(0, 1)), 1'b0);
         tick(acc);
         if (acc) k++;
      end
      check("stream_sent", 32'(k), 32'd10);
      drive(1'b0, p, 1'b1, 1'b0);
      for (int c = 0; c < 8; c++) tick(acc);

      // trap and sidecar fields travel bit-identical
      p = mk(32'h600, 32'h0000_6013);
      p.trap = 4'b0100; p.tag = 32'h8000_0100; p.his = 8'hFF; p.res = 1'b1; p.which = 1'b1;
      drive(1'b1, p, 1'b0, 1'b0);
      tick(acc);
      drive(1'b1, mk(32'h604, 32'h0000_6113), 1'b0, 1'b0);
      tick(acc);
      drive(1'b0, p, 1'b0, 1'b0);
      tick(acc);

      // asynchronous reset with two entries held
      rst = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid_o), 32'd0);
      check("rst_count", 32'(count_o), 32'd0);
      check("rst_in_ready", 32'(in_ready_o), 32'd1);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      tick(acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/if_id_fifo.md
# if_id_fifo

Decoupling instruction queue between the fetch stage (`ifu`) and the decode stage. It captures each valid fetched packet: PC, instruction word, IF trap bits and branch-prediction sidecar. It delivers packets to ID in order through a valid/ready handshake. Fetch keeps running while ID stalls, until the queue fills. A flush from the redirect logic drops every queued packet in one cycle.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, at least 2.
- `TRAP_W`, `` `TRAP_LEN ``: width of the trap bus.
- `HIS_W`, `` `HISLEN ``: width of the branch history.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: drop all entries and any same-cycle enqueue.
- `in_valid_i` in 1: fetch packet valid; driven as `!ram_stall_valid_if_o`.
- `in_ready_o` out 1: queue can accept; equals `!full`.
- `in_pc_i` in 32, `in_inst_i` in 32, `in_trap_i` in TRAP_W: fetch packet.
- `in_pdt_res_i` in 1, `in_pdt_tag_i` in 32, `in_which_pdt_i` in 1, `in_history_i` in HIS_W: prediction sidecar.
- `out_valid_o` out 1: head entry valid.
- `out_ready_i` in 1: ID accepts head; driven as `!id_stall`.
- `out_pc_o`, `out_inst_o`, `out_trap_o`, `out_pdt_res_o`, `out_pdt_tag_o`, `out_which_pdt_o`, `out_history_o`: out; head-entry fields, same widths as the inputs.
- `fetch_stall_o` out 1: pipeline stall request to PC; equals `!in_ready_o`.
- `count_o` out log2(DEPTH)+1: current occupancy.

## Operation
- Storage: DEPTH-entry circular buffer with `wr_ptr` and `rd_ptr` (log2(DEPTH) bits, natural wrap) and `count` (log2(DEPTH)+1 bits).
- Handshake signals:
  - enq = `in_valid_i & in_ready_o & !flush_i`.
  - deq = `out_valid_o & out_ready_i & !flush_i`.
- Enqueue writes all packet fields to `mem[wr_ptr]`, then `wr_ptr` increments.
- Dequeue increments `rd_ptr`.
- Count update: enq only gives +1; deq only gives −1; both or neither leaves it unchanged.
- `full` = (count == DEPTH). `empty` = (count == 0). `out_valid_o` = !empty.
- `in_ready_o` depends only on `full`; there is no combinational path from `out_ready_i`. When full, a simultaneous dequeue does not open a slot in the same cycle.
- Output fields come combinationally from `mem[rd_ptr]` when non-empty. When empty they are forced to a bubble: pc 0, inst 32'h0000_0013 (NOP), trap 0, pdt_res 0, tag 0, which 0, history 0.
- Flush: `wr_ptr`, `rd_ptr` and `count` go to 0 on the next edge. The same-cycle input packet is discarded. Flush has priority over enq and deq.
- Trap bits travel unchanged. A packet carrying a nonzero trap is queued like any other.
- No bypass: a packet enqueued into an empty queue becomes visible on the next cycle.

## Timing
- Reset (asynchronous): pointers 0, count 0. Therefore `out_valid_o`=0, `in_ready_o`=1, `fetch_stall_o`=0, `count_o`=0, and outputs show the bubble values. Storage contents are don't-care.
- Enqueue-to-`out_valid_o` latency: 1 cycle.
- Throughput: 1 packet/cycle sustained when ID is never stalled (count stays at 1).
- Full plus dequeue in cycle N: `in_ready_o` rises in N+1.
- Empty plus `in_valid_i`: no dequeue in that cycle (`out_valid_o`=0).
- Reset asserted mid-operation clears the queue immediately. Packets held in the queue are lost; upstream refetches from the PC reset vector.
- Pointer wrap at DEPTH−1 → 0 is seamless; order is preserved across the wrap.

## Test plan
- Reset, then enqueue pc 0x8000_0000/inst 0x0010_0093 at cycle 1 with `out_ready_i`=1:
  - `out_valid_o`=1 at cycle 2 with those values, `count_o`=1.
  - Queue is empty at cycle 3.
- Hold `out_ready_i`=0 and drive 5 consecutive packets (pc 0x0, 0x4, 0x8, 0xC, 0x10) with DEPTH=4:
  - `in_ready_o`=0 after 4 enqueues; `fetch_stall_o`=1; the 5th is not accepted.
  - Release `out_ready_i`: pcs emerge as 0x0, 0x4, 0x8, 0xC in order.
- Full queue, `out_ready_i`=1 and `in_valid_i`=1 in the same cycle:
  - count drops to 3; the input is not taken that cycle.
  - Next cycle the input is accepted and count returns to 4.
- Three entries queued, `flush_i`=1 together with `in_valid_i`=1:
  - next cycle count=0, `out_valid_o`=0, `out_inst_o`=0x0000_0013.
  - The input packet never appears at the output.
- Stream 10 packets at 1/cycle with random `out_ready_i` stalls: output order matches input order across pointer wrap, with no loss and no duplication.
- Enqueue a packet with a trap bit set and pdt_tag 0x8000_0100, history all-ones: the fields emerge bit-identical. Assert `rst` while 2 entries are held: `out_valid_o`=0 immediately.
